// File: rtl/kamacore_pkg.sv
// rtl/kamacore_pkg.sv - kamacore shared widths, stage payload structs and pipeline state encoding
package kamacore_pkg;

    localparam int CPU_WIDTH      = 32;
    localparam int REG_ADDR_WIDTH = 5;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } pipe_state_e;

    typedef struct packed {
        logic [CPU_WIDTH-1:0] instruction;
    } if_id_t;

    typedef struct packed {
        logic [CPU_WIDTH-1:0]      instruction;
        logic [REG_ADDR_WIDTH-1:0] destination_register;
        logic [CPU_WIDTH-1:0]      data_a;
        logic [CPU_WIDTH-1:0]      data_b;
        logic                      control_alu_src;
        logic                      control_mem_read;
        logic                      control_mem_write;
        logic                      control_reg_write;
        logic                      control_mem_to_reg;
    } id_ex_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] destination_register;
        logic [CPU_WIDTH-1:0]      ex_result;
        logic [CPU_WIDTH-1:0]      read_data_b;
        logic                      control_mem_read;
        logic                      control_mem_write;
        logic                      control_reg_write;
        logic                      control_mem_to_reg;
    } ex_mem_t;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] destination_register;
        logic [CPU_WIDTH-1:0]      ex_result;
        logic [CPU_WIDTH-1:0]      data_memory_result;
        logic                      control_reg_write;
        logic                      control_mem_to_reg;
    } mem_wb_t;

    // Number of valid entries implied by a pipeline state.
    function automatic logic [1:0] occ_of(input pipe_state_e s);
        case (s)
            EMPTY:   return 2'd0;
            ONE:     return 2'd1;
            default: return 2'd2;
        endcase
    endfunction

endpackage

// File: rtl/kamacore_sat_counter.sv
// rtl/kamacore_sat_counter.sv - saturating up-counter for pipeline performance debug
module kamacore_sat_counter #(
    parameter int unsigned CNT_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    output logic [CNT_WIDTH-1:0] count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    logic [CNT_WIDTH-1:0] count_q;
    logic [CNT_WIDTH-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != CNT_MAX)) begin
            count_d = count_q + CNT_ONE;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/kamacore_pipeline_reg.sv
// rtl/kamacore_pipeline_reg.sv - elastic pipeline register with hold, flush, optional skid entry and perf counters
module kamacore_pipeline_reg
    import kamacore_pkg::*;
#(
    parameter int unsigned PAYLOAD_WIDTH = 32,
    parameter int unsigned SKID          = 1,
    parameter int unsigned CNT_WIDTH     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     hold,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [PAYLOAD_WIDTH-1:0] in_data,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [PAYLOAD_WIDTH-1:0] out_data,
    output logic [1:0]               occupancy,
    output logic [CNT_WIDTH-1:0]     stall_cnt,
    output logic [CNT_WIDTH-1:0]     bubble_cnt
);

    pipe_state_e              state_q, state_d;
    logic [PAYLOAD_WIDTH-1:0] head_q, head_d;
    logic [PAYLOAD_WIDTH-1:0] skid_q, skid_d;
    logic [1:0]               occ_q;
    logic                     head_valid;
    logic                     rdy_raw;
    logic                     in_fire;
    logic                     out_fire;

    assign head_valid = (state_q != EMPTY);
    assign in_ready   = rdy_raw & ~hold & ~flush;
    assign out_valid  = head_valid & ~hold & ~flush;
    assign in_fire    = in_valid & in_ready;
    assign out_fire   = out_valid & out_ready;

    generate
        if (SKID != 0) begin : g_skid
            // Ready comes straight from a flop so upstream never sees a path through out_ready.
            logic rdy_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    rdy_q <= 1'b0;
                end else begin
                    rdy_q <= (state_d != FULL);
                end
            end
            assign rdy_raw = rdy_q;
        end else begin : g_single
            // Keeps ready low until the first clock after reset release.
            logic alive_q;
            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    alive_q <= 1'b0;
                end else begin
                    alive_q <= 1'b1;
                end
            end
            assign rdy_raw = alive_q & (~head_valid | out_ready);
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        head_d  = head_q;
        skid_d  = skid_q;
        if (flush) begin
            state_d = EMPTY;
        end else if (!hold) begin
            case (state_q)
                EMPTY: begin
                    if (in_fire) begin
                        state_d = ONE;
                        head_d  = in_data;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        head_d = in_data;
                    end else if (in_fire) begin
                        state_d = FULL;
                        skid_d  = in_data;
                    end else if (out_fire) begin
                        state_d = EMPTY;
                    end
                end
                FULL: begin
                    if (out_fire) begin
                        state_d = ONE;
                        head_d  = skid_q;
                    end
                end
                default: state_d = EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= EMPTY;
            head_q  <= '0;
            skid_q  <= '0;
            occ_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            head_q  <= head_d;
            skid_q  <= skid_d;
            occ_q   <= occ_of(state_d);
        end
    end

    assign out_data  = head_q;
    assign occupancy = occ_q;

    kamacore_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_stall_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (head_valid & (hold | ~out_ready) & ~flush),
        .count(stall_cnt)
    );

    kamacore_sat_counter #(
        .CNT_WIDTH(CNT_WIDTH)
    ) u_bubble_cnt (
        .clk  (clk),
        .rst  (rst),
        .inc  (out_ready & ~out_valid & ~hold),
        .count(bubble_cnt)
    );

endmodule

// File: tb/tb_kamacore_pipeline_reg.sv
// tb/tb_kamacore_pipeline_reg.sv - scoreboard bench for skid and single-entry pipeline registers
module tb_kamacore_pipeline_reg;

    logic        clk       = 1'b0;
    logic        rst       = 1'b0;
    logic        hold      = 1'b0;
    logic        flush     = 1'b0;
    logic        in_valid  = 1'b1;
    logic        out_ready = 1'b1;
    logic [31:0] in_data   = 32'hA5A5_0001;

    logic        a_in_ready, a_out_valid;
    logic [31:0] a_out_data;
    logic [1:0]  a_occ;
    logic [15:0] a_stall, a_bubble;

    logic        b_in_ready, b_out_valid;
    logic [31:0] b_out_data;
    logic [1:0]  b_occ;
    logic [3:0]  b_stall, b_bubble;

    always #5 clk = ~clk;

    kamacore_pipeline_reg #(.PAYLOAD_WIDTH(32), .SKID(1), .CNT_WIDTH(16)) u_skid (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(a_in_ready), .in_data(in_data),
        .out_valid(a_out_valid), .out_ready(out_ready), .out_data(a_out_data),
        .occupancy(a_occ), .stall_cnt(a_stall), .bubble_cnt(a_bubble)
    );

    kamacore_pipeline_reg #(.PAYLOAD_WIDTH(32), .SKID(0), .CNT_WIDTH(4)) u_single (
        .clk(clk), .rst(rst), .hold(hold), .flush(flush),
        .in_valid(in_valid), .in_ready(b_in_ready), .in_data(in_data),
        .out_valid(b_out_valid), .out_ready(out_ready), .out_data(b_out_data),
        .occupancy(b_occ), .stall_cnt(b_stall), .bubble_cnt(b_bubble)
    );

    int          checks = 0;
    int          passed = 0;
    logic [31:0] sb_a[$];
    logic [31:0] sb_b[$];
    int          stall_m[2];
    int          bubble_m[2];
    bit          rdy_m[2];
    bit          alive_m = 1'b0;
    bit          mon_en  = 1'b0;

    // A stage only becomes able to accept after one clock with reset released.
    always @(posedge clk or negedge rst) begin
        if (!rst) alive_m = 1'b0;
        else      alive_m = 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    endtask

    task automatic check_inst(input int k);
        int          sz;
        int          cmax;
        logic [31:0] hd;
        bit          er, ev;
        logic        ir, ov;
        logic [31:0] od;
        logic [1:0]  oc;
        int          st, bu;
        hd = 32'h0;
        if (k == 0) begin
            sz = sb_a.size();
            if (sz > 0) hd = sb_a[0];
            er = alive_m && (sz < 2);
            ir = a_in_ready; ov = a_out_valid; od = a_out_data; oc = a_occ;
            st = int'(a_stall); bu = int'(a_bubble); cmax = 16'hFFFF;
        end else begin
            sz = sb_b.size();
            if (sz > 0) hd = sb_b[0];
            er = alive_m && ((sz == 0) || out_ready);
            ir = b_in_ready; ov = b_out_valid; od = b_out_data; oc = b_occ;
            st = int'(b_stall); bu = int'(b_bubble); cmax = 15;
        end
        er = er && !hold && !flush;
        ev = (sz > 0) && !hold && !flush;
        chk($sformatf("in_ready[%0d]", k), 32'(ir), 32'(er));
        chk($sformatf("out_valid[%0d]", k), 32'(ov), 32'(ev));
        chk($sformatf("occupancy[%0d]", k), 32'(oc), 32'(sz));
        chk($sformatf("stall_cnt[%0d]", k), 32'(st), 32'(stall_m[k]));
        chk($sformatf("bubble_cnt[%0d]", k), 32'(bu), 32'(bubble_m[k]));
        if (hold && !flush && sz > 0) chk($sformatf("hold_data[%0d]", k), od, hd);
        if (ov && out_ready) begin
            if (sz == 0) chk($sformatf("phantom_out[%0d]", k), 32'(ov), 32'h0);
            else begin
                chk($sformatf("out_data[%0d]", k), od, hd);
                if (k == 0) void'(sb_a.pop_front());
                else        void'(sb_b.pop_front());
            end
        end
        if (flush) begin
            if (k == 0) sb_a.delete();
            else        sb_b.delete();
        end
        rdy_m[k] = er;
        if ((sz > 0) && (hold || !out_ready) && !flush && stall_m[k] < cmax) stall_m[k]++;
        if (out_ready && !ev && !hold && bubble_m[k] < cmax) bubble_m[k]++;
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (rst && mon_en) begin
                check_inst(0);
                check_inst(1);
            end
        end
    end

    task automatic clear_model();
        sb_a.delete();
        sb_b.delete();
        for (int k = 0; k < 2; k++) begin
            stall_m[k]  = 0;
            bubble_m[k] = 0;
            rdy_m[k]    = 1'b0;
        end
    endtask

    // One clock of stimulus; accepted payloads become expected outputs.
    task automatic cyc(input bit h, input bit f, input bit iv, input logic [31:0] d, input bit ordy);
        @(posedge clk);
        #1;
        hold = h; flush = f; in_valid = iv; in_data = d; out_ready = ordy;
        @(negedge clk);
        #1;
        if (rst) begin
            if (rdy_m[0] && iv) sb_a.push_back(d);
            if (rdy_m[1] && iv) sb_b.push_back(d);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_a_valid"}, 32'(a_out_valid), 32'h0);
        chk({tag, "_b_valid"}, 32'(b_out_valid), 32'h0);
        chk({tag, "_a_ready"}, 32'(a_in_ready), 32'h0);
        chk({tag, "_b_ready"}, 32'(b_in_ready), 32'h0);
        chk({tag, "_a_occ"}, 32'(a_occ), 32'h0);
        chk({tag, "_a_data"}, a_out_data, 32'h0);
        chk({tag, "_a_stall"}, 32'(a_stall), 32'h0);
        chk({tag, "_a_bubble"}, 32'(a_bubble), 32'h0);
        chk({tag, "_b_stall"}, 32'(b_stall), 32'h0);
        chk({tag, "_b_bubble"}, 32'(b_bubble), 32'h0);
    endtask

    initial begin
        clear_model();
        repeat (2) @(posedge clk);
        #1;
        chk_reset_outputs("reset");
        rst    = 1'b1;
        mon_en = 1'b1;

        cyc(0, 0, 1, 32'hA5A5_0001, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 0, 32'h0, 1);

        cyc(0, 0, 1, 32'h1, 1);
        cyc(0, 0, 1, 32'h2, 0);
        cyc(0, 0, 1, 32'h3, 0);
        cyc(0, 0, 1, 32'h4, 1);
        repeat (4) cyc(0, 0, 0, 32'h0, 1);

        cyc(0, 0, 1, 32'h10, 0);
        cyc(0, 0, 1, 32'h11, 0);
        repeat (3) cyc(1, 0, 1, 32'h12, 1);
        repeat (3) cyc(0, 0, 0, 32'h0, 1);

        cyc(0, 0, 1, 32'h20, 0);
        cyc(0, 0, 1, 32'h21, 0);
        cyc(0, 1, 1, 32'h99, 1);
        cyc(0, 0, 0, 32'h0, 1);
        cyc(0, 0, 1, 32'h30, 0);
        cyc(0, 0, 1, 32'h31, 0);
        cyc(1, 1, 1, 32'h99, 1);
        cyc(0, 0, 0, 32'h0, 1);

        for (int i = 0; i < 300; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 16) == 0, ($urandom % 4) != 0,
                $urandom, ($urandom % 3) != 0);
        end
        repeat (3) cyc(0, 1, 0, 32'h0, 0);

        repeat (20) cyc(0, 0, 0, 32'h0, 1);
        @(negedge clk);
        #2;
        chk("bubble_saturated", 32'(b_bubble), 32'hF);

        repeat (5) cyc(0, 0, 1, $urandom, 0);
        @(negedge clk);
        #2;
        rst = 1'b0;
        #1;
        chk_reset_outputs("async_reset");
        clear_model();
        @(posedge clk);
        #1;
        rst = 1'b1;

        for (int i = 0; i < 100; i++) begin
            cyc(($urandom % 8) == 0, ($urandom % 20) == 0, ($urandom % 3) != 0,
                $urandom, ($urandom % 2) == 0);
        end
        repeat (4) cyc(0, 0, 0, 32'h0, 1);

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
